// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: parameter
// defaults and the response-source encoding of the read-return tracker.
package mem_arb_pkg;

  localparam int unsigned AW_DEF         = 8;
  localparam int unsigned DW_DEF         = 32;
  localparam int unsigned STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_F    = 2'd1,
    RSP_D    = 2'd2
  } rsp_src_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-ported memory,
// data-priority with bounded fetch starvation, and routes 1-cycle read returns.
module mem_port_arbiter #(
  parameter int unsigned AW         = mem_arb_pkg::AW_DEF,
  parameter int unsigned DW         = mem_arb_pkg::DW_DEF,
  parameter int unsigned STARVE_MAX = mem_arb_pkg::STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          stall
);
  import mem_arb_pkg::*;

  localparam int unsigned   CW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  rsp_src_e      rsp_q, rsp_d;

  // Grants are gated by rst_n so every strobe reads 0 while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (f_req && (!d_req || (starve_q == STARVE_LIM))) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    m_en    = f_gnt | d_gnt;
    m_we    = d_gnt & d_we;
    m_addr  = '0;
    m_wdata = '0;
    if (f_gnt) begin
      m_addr = f_addr;
    end else if (d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_we ? d_wdata : '0;
    end
    // One requester is always served when any is pending, so only contention stalls.
    stall = rst_n & f_req & d_req;
  end

  always_comb begin
    starve_d = starve_q;
    if (!f_req || f_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_comb begin
    rsp_d = RSP_NONE;
    if (f_gnt) begin
      rsp_d = RSP_F;
    end else if (d_gnt && !d_we) begin
      rsp_d = RSP_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      rsp_q    <= RSP_NONE;
    end else begin
      starve_q <= starve_d;
      rsp_q    <= rsp_d;
    end
  end

  always_comb begin
    f_valid = 1'b0;
    d_valid = 1'b0;
    f_rdata = '0;
    d_rdata = '0;
    case (rsp_q)
      RSP_F: begin
        f_valid = 1'b1;
        f_rdata = m_rdata;
      end
      RSP_D: begin
        d_valid = 1'b1;
        d_rdata = m_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 256-word
// synchronous memory model attached to the memory port.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_req, d_req, d_we;
  logic [7:0]  f_addr, d_addr;
  logic [31:0] d_wdata;
  logic        f_gnt, f_valid, d_gnt, d_valid;
  logic [31:0] f_rdata, d_rdata;
  logic        m_en, m_we, stall;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];
  logic        mem_ready = 1'b0;

  mem_port_arbiter #(.AW(8), .DW(32), .STARVE_MAX(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_gnt   (f_gnt),
    .f_valid (f_valid),
    .f_rdata (f_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_valid (d_valid),
    .d_rdata (d_rdata),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return 32'hC000_0000 | {24'h0, a};
  endfunction

  // Memory contents are seeded on the first edges, which fall inside reset.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
      mem[11]   <= 32'h2001_0005;
      mem_ready <= 1'b1;
    end else if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set(input logic fr, input logic [7:0] fa, input logic dr,
                     input logic we, input logic [7:0] da, input logic [31:0] wd);
    f_req = fr; f_addr = fa; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    #1;
  endtask

  task automatic drive(input logic fr, input logic [7:0] fa, input logic dr,
                       input logic we, input logic [7:0] da, input logic [31:0] wd);
    @(negedge clk);
    set(fr, fa, dr, we, da, wd);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {57'h0, f_gnt, d_gnt, f_valid, d_valid, m_en, m_we, stall}, 64'h0);
    check({tag, "_maddr"}, {56'h0, m_addr}, 64'h0);
    check({tag, "_mwdata"}, {32'h0, m_wdata}, 64'h0);
    check({tag, "_rdata"}, {f_rdata, d_rdata}, 64'h0);
  endtask

  logic [7:0] pat;
  logic [7:0] a;
  logic       ef;

  initial begin
    rst_n = 1'b0;
    set(1'b1, 8'h55, 1'b1, 1'b1, 8'hAA, 32'h1234_5678);
    check_idle("rst_hold");
    tick;
    tick;
    check_idle("rst_after_edge");

    // Single fetch, granted on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    set(1'b1, 8'd11, 1'b0, 1'b0, 8'd0, 32'h0);
    check("f_only_fgnt", f_gnt, 1'b1);
    check("f_only_dgnt", d_gnt, 1'b0);
    check("f_only_men_mwe", {m_en, m_we}, 2'b10);
    check("f_only_maddr", m_addr, 8'd11);
    check("f_only_stall", stall, 1'b0);
    tick;
    check("f_only_fvalid", f_valid, 1'b1);
    check("f_only_frdata", f_rdata, 32'h2001_0005);
    check("f_only_dvalid", d_valid, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'h0);
    check("idle_men", m_en, 1'b0);
    tick;
    check("idle_valids", {f_valid, d_valid}, 2'b00);

    // Store then load to the same word.
    drive(1'b0, 8'd0, 1'b1, 1'b1, 8'd4, 32'hDEAD_BEEF);
    check("st_dgnt", d_gnt, 1'b1);
    check("st_mwe", m_we, 1'b1);
    check("st_maddr", m_addr, 8'd4);
    check("st_mwdata", m_wdata, 32'hDEAD_BEEF);
    tick;
    check("st_no_dvalid", d_valid, 1'b0);
    drive(1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 32'h0);
    check("ld_dgnt", d_gnt, 1'b1);
    check("ld_mwe", m_we, 1'b0);
    tick;
    check("ld_dvalid", d_valid, 1'b1);
    check("ld_drdata", d_rdata, 32'hDEAD_BEEF);
    check("ld_fvalid", f_valid, 1'b0);

    // Contention: bit i set means fetch wins cycle i.
    pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++) begin
      ef = pat[i];
      drive(1'b1, 8'd20, 1'b1, 1'b0, 8'd30, 32'h0);
      check($sformatf("arb%0d_gnt", i), {f_gnt, d_gnt}, {ef, ~ef});
      check($sformatf("arb%0d_stall", i), stall, 1'b1);
      tick;
      check($sformatf("arb%0d_valid", i), {f_valid, d_valid}, {ef, ~ef});
      if (ef) check($sformatf("arb%0d_frdata", i), f_rdata, init_word(8'd20));
      else    check($sformatf("arb%0d_drdata", i), d_rdata, init_word(8'd30));
    end

    // Alternating fetch and load, back to back.
    for (int i = 0; i < 6; i++) begin
      ef = (i % 2 == 0);
      a  = ef ? 8'(40 + i) : 8'(60 + i);
      drive(ef, a, ~ef, 1'b0, a, 32'h0);
      check($sformatf("alt%0d_gnt", i), {f_gnt, d_gnt}, {ef, ~ef});
      tick;
      check($sformatf("alt%0d_valid", i), {f_valid, d_valid}, {ef, ~ef});
      check($sformatf("alt%0d_rdata", i), {f_rdata, d_rdata},
            ef ? {init_word(a), 32'h0} : {32'h0, init_word(a)});
    end

    // Reset right after a fetch grant drops the pending return.
    drive(1'b1, 8'd11, 1'b0, 1'b0, 8'd0, 32'h0);
    check("rstf_fgnt", f_gnt, 1'b1);
    tick;
    rst_n = 1'b0;
    set(1'b1, 8'd11, 1'b1, 1'b0, 8'd30, 32'h0);
    check_idle("rstf_during");
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'h0);
    rst_n = 1'b1;
    tick;
    check("rstf_no_valid", {f_valid, d_valid}, 2'b00);

    // Reset clears a partially built starvation count.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'd20, 1'b1, 1'b0, 8'd30, 32'h0);
      check($sformatf("pre%0d_dgnt", i), {f_gnt, d_gnt}, 2'b01);
      tick;
    end
    rst_n = 1'b0;
    #1;
    check_idle("rsts_during");
    tick;
    rst_n = 1'b1;
    pat = 8'b0000_1000;
    for (int i = 0; i < 4; i++) begin
      ef = pat[i];
      drive(1'b1, 8'd20, 1'b1, 1'b0, 8'd30, 32'h0);
      check($sformatf("post%0d_gnt", i), {f_gnt, d_gnt}, {ef, ~ef});
      tick;
    end

    // Data alone for five cycles, then fetch joins and waits at most three.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'd0, 1'b1, 1'b0, 8'd50, 32'h0);
      check($sformatf("donly%0d_gnt", i), {f_gnt, d_gnt, stall}, 3'b010);
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      ef = pat[i];
      drive(1'b1, 8'd21, 1'b1, 1'b0, 8'd50, 32'h0);
      check($sformatf("join%0d_gnt", i), {f_gnt, d_gnt, stall}, {ef, ~ef, 1'b1});
      tick;
    end

    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 32'h0);
    tick;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, meaning word-address width (matches the 8-bit program counter).
REQ-002 SHALL have parameter DW, default 32, meaning data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, meaning the maximum number of consecutive data grants while fetch waits.
REQ-004 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 f_req  in  1  fetch read request.
REQ-007 f_addr  in  AW  fetch word address.
REQ-008 f_gnt  out  1  fetch access issued this cycle.
REQ-009 f_valid  out  1  fetch read data valid.
REQ-010 f_rdata  out  DW  fetch read data.
REQ-011 d_req  in  1  data request (load or store).
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  AW  data word address.
REQ-014 d_wdata  in  DW  store data.
REQ-015 d_gnt  out  1  data access issued this cycle.
REQ-016 d_valid  out  1  load data valid.
REQ-017 d_rdata  out  DW  load data.
REQ-018 m_en  out  1  memory access strobe.
REQ-019 m_we  out  1  memory write enable.
REQ-020 m_addr  out  AW  memory address.
REQ-021 m_wdata  out  DW  memory write data.
REQ-022 m_rdata  in  DW  memory read data, valid one cycle after m_en with m_we=0.
REQ-023 stall  out  1  asserted when f_req or d_req is pending and not granted this cycle.

Function
REQ-024 SHALL issue at most one memory access per cycle; m_en, m_we, m_addr, m_wdata, f_gnt and d_gnt SHALL be combinational from the requests and the arbitration state.
REQ-025 Requesters SHALL hold req and their address/data stable until gnt; a gnt SHALL consume exactly one request.
REQ-026 With only one request pending, it SHALL be granted in the same cycle.
REQ-027 With both pending, data SHALL win unless starve_cnt == STARVE_MAX, in which case fetch SHALL win.
REQ-028 starve_cnt SHALL increment, saturating at STARVE_MAX, on a data grant while f_req=1; it SHALL clear on a fetch grant or in any cycle with f_req=0.
REQ-029 Response tracker states: RSP_NONE, RSP_F, RSP_D; next state = RSP_F on a fetch grant, RSP_D on a data load grant, else RSP_NONE (including stores).
REQ-030 In RSP_F, f_valid=1 and f_rdata=m_rdata; in RSP_D, d_valid=1 and d_rdata=m_rdata; otherwise both valid outputs=0 and rdata outputs=0.
REQ-031 Read latency SHALL be exactly 1 cycle from gnt to valid; back-to-back grants SHALL be supported with one response per cycle.
REQ-032 A store SHALL complete at d_gnt: m_we=1, m_wdata=d_wdata, with no d_valid pulse.
REQ-033 A store immediately followed by a load to the same address SHALL return the stored data, since memory write-before-read ordering is preserved by issue order.
REQ-034 Addresses SHALL pass unmodified; AW-bit wrap-around is the requester's responsibility.

Reset
REQ-035 While rst_n=0: starve_cnt=0, tracker=RSP_NONE, all gnt/valid/m_en/m_we/stall=0, and all data/address outputs=0.
REQ-036 Reset asserted mid-read SHALL discard the in-flight response, with no valid pulse after release.
REQ-037 The first grant SHALL be possible in the first rising edge cycle after rst_n deasserts.

Structure
REQ-038 A shared package mem_arb_pkg SHALL hold the response-source enum (RSP_NONE/RSP_F/RSP_D) and the AW/DW/STARVE_MAX defaults.
REQ-039 The block SHALL be a single module with no sub-modules; the memory itself SHALL remain external.

Verification
REQ-040 f_req=1 alone, f_addr=8'd11, m_rdata=32'h20010005 -> f_gnt same cycle, f_valid=1 with f_rdata=32'h20010005 next cycle, d_valid=0.
REQ-041 Store d_we=1, d_addr=8'd4, d_wdata=32'hDEADBEEF, then load d_addr=8'd4 -> m_we=1 on cycle 1, d_valid=1 with d_rdata=32'hDEADBEEF on cycle 3, no d_valid on cycle 2.
REQ-042 f_req and d_req both held high for 8 cycles -> grants D,D,D,F,D,D,D,F; stall=1 every cycle.
REQ-043 Alternating fetch/load grants back-to-back -> one valid per cycle, routed to the correct port, and never both valids high.
REQ-044 rst_n=0 for 1 cycle immediately after a fetch grant -> no f_valid afterwards, starve_cnt=0, and all outputs 0 during reset.
REQ-045 d_req held with f_req=0 for 5 cycles, then f_req=1 -> fetch waits at most STARVE_MAX=3 data grants.
